// File: rtl/apb_converter.sv
// apb_converter: APB3 width bridge, splitting each upstream transfer into N narrower downstream transfers.
// The lowest-addressed byte travels in the most significant byte lane of each bus.
module apb_converter #(
    parameter int ADDRM_WIDTH = 13,
    parameter int DATAM_WIDTH = 32,
    parameter int ADDRS_WIDTH = 13,
    parameter int DATAS_WIDTH = 32
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    input  logic                   in_PSEL,
    input  logic                   in_PENABLE,
    input  logic                   in_PWRITE,
    input  logic [ADDRM_WIDTH-1:0] in_PADDR,
    input  logic [DATAM_WIDTH-1:0] in_PWDATA,
    output logic [DATAM_WIDTH-1:0] in_PRDATA,
    output logic                   in_PREADY,
    output logic                   in_PSLVERR,
    output logic                   out_PSEL,
    output logic                   out_PENABLE,
    output logic                   out_PWRITE,
    output logic [ADDRS_WIDTH-1:0] out_PADDR,
    output logic [DATAS_WIDTH-1:0] out_PWDATA,
    input  logic [DATAS_WIDTH-1:0] out_PRDATA,
    input  logic                   out_PREADY,
    input  logic                   out_PSLVERR
);
    localparam int N  = DATAM_WIDTH / DATAS_WIDTH;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    localparam int SB = DATAS_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t                 state, state_nx;
    logic [ADDRM_WIDTH-1:0] addr_q;
    logic                   write_q;
    logic [DATAM_WIDTH-1:0] wdata_q, rdata_q, ins, mask;
    logic [KW-1:0]          k;
    logic                   err, last, start;
    int                     sh_r;

    assign start = state == IDLE && in_PSEL && !in_PENABLE;
    assign last  = int'(k) == N - 1;
    // Slice k sits (N-1-k) slices up from bit 0
    assign sh_r  = (N - 1 - int'(k)) * DATAS_WIDTH;
    assign ins   = DATAM_WIDTH'(out_PRDATA) << sh_r;
    assign mask  = DATAM_WIDTH'({DATAS_WIDTH{1'b1}}) << sh_r;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SETUP : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = !out_PREADY ? ACCESS : (out_PSLVERR || last) ? DONE : SETUP;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            k       <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_nx;
            if (start) begin
                addr_q  <= in_PADDR;
                write_q <= in_PWRITE;
                wdata_q <= in_PWDATA;
                k       <= '0;
                err     <= 1'b0;
            end
            if (state == ACCESS && out_PREADY) begin
                if (!write_q) rdata_q <= (rdata_q & ~mask) | ins;
                err <= err | out_PSLVERR;
                if (!out_PSLVERR && !last) k <= k + 1'b1;
            end
        end
    end

    assign out_PSEL    = state == SETUP || state == ACCESS;
    assign out_PENABLE = state == ACCESS;
    assign out_PWRITE  = write_q;
    assign out_PADDR   = ADDRS_WIDTH'(addr_q) + ADDRS_WIDTH'(int'(k) * SB);
    assign out_PWDATA  = DATAS_WIDTH'(wdata_q >> sh_r);
    assign in_PREADY   = state == DONE;
    assign in_PSLVERR  = state == DONE && err;
    assign in_PRDATA   = rdata_q;
endmodule

// File: tb/tb_apb_converter.sv
// tb_apb_converter: drives a 32->32 and a 32->16 bridge against byte-memory slaves and a byte-level reference model.
module tb_apb_converter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        ipsel[2], ipen[2], ipwr[2], iprdy[2], iperr[2];
    logic [12:0] ipaddr[2];
    logic [31:0] ipwdata[2], iprdata[2];
    int          wait_n[2];
    bit          err_en[2];

    logic [7:0]  ref_mem[2][8192];
    logic [31:0] exp_prd[2];
    bit          prd_ok[2];
    int          n_vec = 0, n_err = 0;

    for (genvar g = 0; g < 2; g++) begin : gs
        localparam int DW = g == 0 ? 32 : 16;
        logic          psel, pen, pwr, prdy, perr;
        logic [12:0]   pa, sa;
        logic [DW-1:0] pwd, prd, sd;
        logic [7:0]    mem[8192] = '{default: 8'h00};
        int            cnt = 0;
        logic          bad = 1'b0;
        logic [45:0]   wlog[$];

        apb_converter #(.DATAS_WIDTH(DW)) dut (
            .PCLK(clk), .PRESET(rst),
            .in_PSEL(ipsel[g]), .in_PENABLE(ipen[g]), .in_PWRITE(ipwr[g]),
            .in_PADDR(ipaddr[g]), .in_PWDATA(ipwdata[g]), .in_PRDATA(iprdata[g]),
            .in_PREADY(iprdy[g]), .in_PSLVERR(iperr[g]),
            .out_PSEL(psel), .out_PENABLE(pen), .out_PWRITE(pwr),
            .out_PADDR(pa), .out_PWDATA(pwd), .out_PRDATA(prd),
            .out_PREADY(prdy), .out_PSLVERR(perr)
        );

        assign prdy = psel & pen & (cnt == wait_n[g]);
        assign perr = prdy & err_en[g];

        always_comb begin
            prd = '0;
            for (int i = 0; i < DW / 8; i++) prd[DW-1-8*i -: 8] = mem[13'(pa + 13'(i))];
        end

        always @(posedge clk) begin
            cnt <= (psel & pen & !prdy) ? cnt + 1 : 0;
            if (psel & !pen) begin
                sa <= pa;
                sd <= pwd;
            end
            if (psel && pen && (pa != sa || pwd != sd)) bad <= 1'b1;
            if (prdy) begin
                wlog.push_back({pwr, pa, 32'(pwd)});
                if (pwr & !perr)
                    for (int i = 0; i < DW / 8; i++) mem[13'(pa + 13'(i))] <= pwd[DW-1-8*i -: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One upstream transfer; inputs are scrambled after setup since the bridge must use its latched copy
    task automatic xfer(input int g, input bit wr, input logic [12:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int cyc);
        ipsel[g] = 1'b1; ipen[g] = 1'b0; ipwr[g] = wr; ipaddr[g] = a; ipwdata[g] = wd;
        @(posedge clk); #1;
        ipen[g] = 1'b1; ipaddr[g] = 13'($urandom); ipwdata[g] = $urandom; ipwr[g] = $urandom_range(0, 1);
        cyc = 1;
        while (!iprdy[g] && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        rd = iprdata[g];
        er = iperr[g];
        @(posedge clk); #1;
        ipsel[g] = 1'b0; ipen[g] = 1'b0;
    endtask

    task automatic do_op(input int g, input bit wr, input logic [12:0] a, input logic [31:0] wd,
                         input int w, input bit e);
        logic [31:0] rd, exp;
        logic        er;
        int          cyc, subs;
        string       s;
        s = $sformatf("g%0d %s @%0h", g, wr ? "wr" : "rd", a);
        wait_n[g] = w;
        err_en[g] = e;
        xfer(g, wr, a, wd, rd, er, cyc);
        subs = e ? 1 : (g == 0 ? 1 : 2);
        check({s, " cycles"}, 64'(cyc), 64'(1 + subs * (2 + w)));
        check({s, " pslverr"}, 64'(er), 64'(e));
        exp = '0;
        for (int i = 0; i < 4; i++) exp = {exp[23:0], ref_mem[g][13'(a + 13'(i))]};
        if (!wr && !e) begin
            check({s, " rdata"}, 64'(rd), 64'(exp));
            exp_prd[g] = exp;
            prd_ok[g] = 1'b1;
        end else if (!wr) begin
            prd_ok[g] = 1'b0;
        end else begin
            if (prd_ok[g]) check({s, " rdata_hold"}, 64'(rd), 64'(exp_prd[g]));
            if (!e) for (int i = 0; i < 4; i++) ref_mem[g][13'(a + 13'(i))] = wd[31-8*i -: 8];
        end
        err_en[g] = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        check({tag, " g0 down"}, {gs[0].psel, gs[0].pen, gs[0].pwr, gs[0].pa, gs[0].pwd}, 64'h0);
        check({tag, " g1 down"}, {gs[1].psel, gs[1].pen, gs[1].pwr, gs[1].pa, gs[1].pwd}, 64'h0);
        check({tag, " g0 up"}, {iprdy[0], iperr[0], iprdata[0]}, 64'h0);
        check({tag, " g1 up"}, {iprdy[1], iperr[1], iprdata[1]}, 64'h0);
    endtask

    initial begin
        logic [31:0] d;
        logic [12:0] a;
        int          g;
        for (int i = 0; i < 2; i++) begin
            ipsel[i] = 0; ipen[i] = 0; ipwr[i] = 0; ipaddr[i] = 0; ipwdata[i] = 0;
            wait_n[i] = 0; err_en[i] = 0; exp_prd[i] = 0; prd_ok[i] = 1;
            for (int j = 0; j < 8192; j++) ref_mem[i][j] = 8'h00;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk_idle("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        gs[0].wlog.delete();
        do_op(0, 1, 13'h005, 32'hA1B2C3D4, 0, 0);
        check("g0 single wlog", 64'(gs[0].wlog.size()), 64'd1);
        check("g0 wr down", 64'(gs[0].wlog[0]), {18'h0, 1'b1, 13'h005, 32'hA1B2C3D4});
        do_op(0, 0, 13'h005, 0, 0, 0);
        check("g0 readback", 64'(exp_prd[0]), 64'hA1B2C3D4);

        for (int i = 0; i <= 252; i++) begin
            d = $urandom;
            do_op(0, 1, 13'(i), d, 0, 0);
            do_op(0, 0, 13'(i), 0, 0, 0);
        end

        do_op(0, 1, 13'h040, 32'h5A5AC3C3, 3, 0);
        do_op(0, 0, 13'h040, 0, 3, 0);
        do_op(0, 1, 13'h044, 32'hDEADBEEF, 0, 1);
        do_op(0, 1, 13'h044, 32'h01020304, 0, 0);
        do_op(0, 0, 13'h044, 0, 0, 0);

        gs[1].wlog.delete();
        do_op(1, 1, 13'h010, 32'h11223344, 0, 0);
        check("g1 split count", 64'(gs[1].wlog.size()), 64'd2);
        check("g1 split hi", 64'(gs[1].wlog[0]), {18'h0, 1'b1, 13'h010, 32'h1122});
        check("g1 split lo", 64'(gs[1].wlog[1]), {18'h0, 1'b1, 13'h012, 32'h3344});
        do_op(1, 0, 13'h010, 0, 0, 0);
        check("g1 reassembled", 64'(exp_prd[1]), 64'h11223344);
        do_op(1, 1, 13'h1FFF, 32'hCAFEF00D, 1, 0);
        do_op(1, 0, 13'h1FFF, 0, 2, 0);

        for (int i = 0; i < 200; i++) begin
            g = $urandom_range(0, 1);
            a = ($urandom_range(0, 7) == 0) ? 13'(8188 + $urandom_range(0, 3)) : 13'($urandom_range(0, 63));
            do_op(g, $urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 7) == 0);
        end

        wait_n[1] = 3;
        ipsel[1] = 1'b1; ipen[1] = 1'b0; ipwr[1] = 1'b0; ipaddr[1] = 13'h020;
        @(posedge clk); #1;
        ipen[1] = 1'b1;
        @(posedge clk); #1;
        check("g1 in access", {gs[1].psel, gs[1].pen}, 64'h3);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_idle("mid reset");
        rst = 1'b0; ipsel[1] = 1'b0; ipen[1] = 1'b0;
        exp_prd[1] = 0; prd_ok[1] = 1'b1;
        @(posedge clk); #1;
        d = $urandom;
        do_op(1, 1, 13'h030, d, 0, 0);
        do_op(1, 0, 13'h030, 0, 0, 0);
        check("g1 post reset rd", 64'(exp_prd[1]), 64'(d));

        check("g0 stable", 64'(gs[0].bad), 64'h0);
        check("g1 stable", 64'(gs[1].bad), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
